// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t ISSUE = 2'd1;
  localparam arb_state_t WAIT  = 2'd2;
  localparam arb_state_t RESP  = 2'd3;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/mem_arb_if.sv
// Core fetch/data ports plus the memory-side bus of the arbiter, bundled as one interface.
interface mem_arb_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_rd_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_rd_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  // Arbiter side.
  modport master (
    input  i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_rd_wr, mem_addr, mem_wdata, busy
  );

  // Core and memory side.
  modport slave (
    output i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_rd_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Loadable 4-bit down-counter timing the memory WAIT phase; o_done flags a zero count.
module mem_arb_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_done
);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data ports onto one fixed-latency memory, data first with an
// anti-starvation counter. Define MEM_ARB_PERF_EN to add grant/stall performance counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_stall_cycles,
`endif
  mem_arb_if.master   bus
);

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t  r_state;
  arb_owner_t  r_owner;
  logic [3:0]  r_starve;
  logic        r_i_ack;
  logic        r_d_ack;
  logic        r_mem_en;
  logic        r_mem_rd_wr;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_timer_done;

  // Grants are only acted on in IDLE; data wins unless instruction has been starved.
  always_comb begin
    w_grant_d = bus.d_req && !(bus.i_req && (r_starve == STARVE_MAX));
    w_grant_i = bus.i_req && !w_grant_d;
  end

  mem_arb_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state == ISSUE),
    .i_load_val (LAT_LOAD),
    .i_dec      (r_state == WAIT),
    .o_done     (w_timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_INSTR;
      r_starve    <= 4'd0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_rd_wr <= MEM_READ;
      r_i_rdata   <= 32'd0;
      r_d_rdata   <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_en <= 1'b0;
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= ISSUE;
            r_owner     <= OWN_DATA;
            r_mem_en    <= 1'b1;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_mem_rd_wr <= bus.d_rd_wr;
            if (bus.i_req && (r_starve != STARVE_MAX)) begin
              r_starve <= r_starve + 4'd1;
            end
          end else if (w_grant_i) begin
            r_state     <= ISSUE;
            r_owner     <= OWN_INSTR;
            r_mem_en    <= 1'b1;
            r_mem_addr  <= bus.i_addr;
            r_mem_rd_wr <= MEM_READ;
            r_starve    <= 4'd0;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (w_timer_done) begin
            r_state <= RESP;
            if (r_owner == OWN_INSTR) begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= bus.mem_rdata;
            end else begin
              r_d_ack <= 1'b1;
              if (r_mem_rd_wr == MEM_READ) begin
                r_d_rdata <= bus.mem_rdata;
              end
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_rd_wr <= MEM_READ;
        end
      endcase
    end
  end

  assign bus.i_ack     = r_i_ack;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_rd_wr = r_mem_rd_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = (r_state != IDLE);

`ifdef MEM_ARB_PERF_EN
  logic        w_stall;
  logic [31:0] r_perf_i;
  logic [31:0] r_perf_d;
  logic [31:0] r_perf_stall;

  // A request stalls whenever it is high but its port does not currently own the memory.
  always_comb begin
    w_stall = (bus.i_req && !((r_state != IDLE) && (r_owner == OWN_INSTR))) ||
              (bus.d_req && !((r_state != IDLE) && (r_owner == OWN_DATA)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_i     <= 32'd0;
      r_perf_d     <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if ((r_state == IDLE) && w_grant_i) r_perf_i <= r_perf_i + 32'd1;
      if ((r_state == IDLE) && w_grant_d) r_perf_d <= r_perf_d + 32'd1;
      if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_i_grants     = r_perf_i;
  assign perf_d_grants     = r_perf_d;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned STARVE  = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arb_if u_bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i;
  logic [31:0] perf_d;
  logic [31:0] perf_stall;
`endif

  mem_arbiter #(
    .MEM_LATENCY  (MEM_LAT),
    .STARVE_LIMIT (STARVE)
  ) u_dut (
    .clk               (clk),
    .reset             (reset),
`ifdef MEM_ARB_PERF_EN
    .perf_i_grants     (perf_i),
    .perf_d_grants     (perf_d),
    .perf_stall_cycles (perf_stall),
`endif
    .bus               (u_bus)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: read data valid only in the cycle MEM_LAT cycles after the mem_en cycle.
  int unsigned m_cnt;
  logic [31:0] m_addr;
  always @(posedge clk) begin
    if (reset) begin
      m_cnt  <= 0;
      m_addr <= 32'd0;
    end else if (u_bus.mem_en && u_bus.mem_rd_wr) begin
      m_cnt  <= 1;
      m_addr <= u_bus.mem_addr;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign u_bus.mem_rdata = (m_cnt == MEM_LAT) ? mem_model(m_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input vec_t v);
    if (v.is_d) begin
      u_bus.d_req = 1'b1; u_bus.d_rd_wr = v.rd; u_bus.d_addr = v.addr; u_bus.d_wdata = v.wdata;
    end else begin
      u_bus.i_req = 1'b1; u_bus.i_addr = v.addr;
    end
    chk("c0_busy", 32'(u_bus.busy), 32'd0);
    chk("c0_mem_en", 32'(u_bus.mem_en), 32'd0);
    step();
    chk("issue_mem_en", 32'(u_bus.mem_en), 32'd1);
    chk("issue_addr", u_bus.mem_addr, v.addr);
    chk("issue_rd_wr", 32'(u_bus.mem_rd_wr), 32'(v.rd));
    if (!v.rd) chk("issue_wdata", u_bus.mem_wdata, v.wdata);
    chk("issue_busy", 32'(u_bus.busy), 32'd1);
    for (int c = 0; c < int'(MEM_LAT); c++) begin
      step();
      chk("wait_mem_en", 32'(u_bus.mem_en), 32'd0);
      chk("wait_acks", 32'({u_bus.i_ack, u_bus.d_ack}), 32'd0);
    end
    step();
    chk("resp_i_ack", 32'(u_bus.i_ack), 32'(!v.is_d));
    chk("resp_d_ack", 32'(u_bus.d_ack), 32'(v.is_d));
    if (v.is_d) chk("resp_d_rdata", u_bus.d_rdata, v.exp_rdata);
    else        chk("resp_i_rdata", u_bus.i_rdata, v.exp_rdata);
    u_bus.i_req = 1'b0;
    u_bus.d_req = 1'b0;
    step();
    chk("post_acks", 32'({u_bus.i_ack, u_bus.d_ack}), 32'd0);
    chk("post_busy", 32'(u_bus.busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_i_ack"}, 32'(u_bus.i_ack), 32'd0);
    chk({tag, "_d_ack"}, 32'(u_bus.d_ack), 32'd0);
    chk({tag, "_mem_en"}, 32'(u_bus.mem_en), 32'd0);
    chk({tag, "_busy"}, 32'(u_bus.busy), 32'd0);
    chk({tag, "_rd_wr"}, 32'(u_bus.mem_rd_wr), 32'd1);
    chk({tag, "_i_rdata"}, u_bus.i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, u_bus.d_rdata, 32'd0);
    chk({tag, "_mem_addr"}, u_bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, u_bus.mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] cur_d;
    logic [31:0] cur_i;
    logic        is_d;
    logic        exp_d;
    logic [31:0] prev_stall;

    vecs[0] = '{is_d: 1'b0, rd: 1'b1, addr: 32'h100, wdata: 32'h0, exp_rdata: 32'hDEAD_BEEF};
    vecs[1] = '{is_d: 1'b1, rd: 1'b0, addr: 32'h40, wdata: 32'h1234, exp_rdata: 32'h0};
    vecs[2] = '{is_d: 1'b1, rd: 1'b1, addr: 32'h80, wdata: 32'h0, exp_rdata: 32'h0080_FF7F};
    vecs[3] = '{is_d: 1'b1, rd: 1'b0, addr: 32'h44, wdata: 32'hCAFE_0001,
                exp_rdata: 32'h0080_FF7F};
    vecs[4] = '{is_d: 1'b0, rd: 1'b1, addr: 32'h200, wdata: 32'h0, exp_rdata: 32'h0200_FDFF};
    vecs[5] = '{is_d: 1'b1, rd: 1'b1, addr: 32'h100, wdata: 32'h0, exp_rdata: 32'hDEAD_BEEF};

    u_bus.i_req = 1'b0; u_bus.i_addr = 32'd0;
    u_bus.d_req = 1'b0; u_bus.d_rd_wr = 1'b1; u_bus.d_addr = 32'd0; u_bus.d_wdata = 32'd0;
    reset = 1'b1;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    for (int k = 0; k < 6; k++) run_txn(vecs[k]);

    // Data request arrives while an instruction access is in WAIT.
    u_bus.i_req = 1'b1; u_bus.i_addr = 32'h300;
    step();
    chk("mid_i_issue", u_bus.mem_addr, 32'h300);
    step();
    u_bus.d_req = 1'b1; u_bus.d_rd_wr = 1'b1; u_bus.d_addr = 32'h84;
    chk("mid_busy_wait", 32'(u_bus.busy), 32'd1);
    for (int c = 1; c < int'(MEM_LAT); c++) begin
      step();
      chk("mid_no_d_ack", 32'(u_bus.d_ack), 32'd0);
    end
    step();
    chk("mid_i_ack", 32'(u_bus.i_ack), 32'd1);
    chk("mid_d_ack_idle", 32'(u_bus.d_ack), 32'd0);
    chk("mid_i_rdata", u_bus.i_rdata, 32'h0300_FCFF);
    chk("mid_busy_resp", 32'(u_bus.busy), 32'd1);
    u_bus.i_req = 1'b0;
    step();
    chk("mid_gap_mem_en", 32'(u_bus.mem_en), 32'd0);
    step();
    chk("mid_d_issue_en", 32'(u_bus.mem_en), 32'd1);
    chk("mid_d_issue_addr", u_bus.mem_addr, 32'h84);
    chk("mid_d_busy", 32'(u_bus.busy), 32'd1);
    for (int c = 0; c < int'(MEM_LAT); c++) begin
      step();
      chk("mid_d_wait_busy", 32'(u_bus.busy), 32'd1);
    end
    step();
    chk("mid_d_ack", 32'(u_bus.d_ack), 32'd1);
    chk("mid_d_rdata", u_bus.d_rdata, 32'h0084_FF7B);
    u_bus.d_req = 1'b0;
    step();

    // Reset during the WAIT phase of a write.
    u_bus.d_req = 1'b1; u_bus.d_rd_wr = 1'b0; u_bus.d_addr = 32'h48; u_bus.d_wdata = 32'h55;
    step();
    chk("rw_issue_rd_wr", 32'(u_bus.mem_rd_wr), 32'd0);
    step();
    reset = 1'b1;
    u_bus.d_req = 1'b0; u_bus.d_rd_wr = 1'b1;
    step();
    chk_reset_vals("midrst");
    reset = 1'b0;
    for (int c = 0; c < int'(MEM_LAT) + 3; c++) begin
      step();
      chk("midrst_no_ack", 32'({u_bus.d_ack, u_bus.mem_en}), 32'd0);
    end
    run_txn(vecs[0]);

    // Contention: both requests held back to back.
    reset = 1'b1;
    step();
    reset = 1'b0;
    cur_d = 32'h1000;
    cur_i = 32'h2000;
    prev_stall = 32'd0;
    u_bus.d_req = 1'b1; u_bus.d_rd_wr = 1'b1; u_bus.d_addr = cur_d;
    u_bus.i_req = 1'b1; u_bus.i_addr = cur_i;
    for (int g = 0; g < 20; g++) begin
      int n;
      exp_d = ((g % 5) != 4);
      n = 0;
      while (!u_bus.mem_en && n < 20) begin
        step();
        n++;
      end
      chk("cont_grant_seen", 32'(u_bus.mem_en), 32'd1);
      is_d = (u_bus.mem_addr == cur_d);
      chk("cont_grant_owner", 32'(is_d), 32'(exp_d));
`ifdef MEM_ARB_PERF_EN
      chk("perf_stall_mono", 32'(perf_stall >= prev_stall), 32'd1);
      prev_stall = perf_stall;
`endif
      n = 0;
      while (!(u_bus.i_ack || u_bus.d_ack) && n < 20) begin
        step();
        n++;
      end
      chk("cont_ack_seen", 32'(u_bus.i_ack || u_bus.d_ack), 32'd1);
      chk("cont_ack_owner", 32'(u_bus.d_ack), 32'(exp_d));
      if (u_bus.d_ack) begin
        chk("cont_d_rdata", u_bus.d_rdata, mem_model(cur_d));
        cur_d = cur_d + 32'd4;
        u_bus.d_addr = cur_d;
      end else if (u_bus.i_ack) begin
        chk("cont_i_rdata", u_bus.i_rdata, mem_model(cur_i));
        cur_i = cur_i + 32'd4;
        u_bus.i_addr = cur_i;
      end
      if (g == 19) begin
        u_bus.d_req = 1'b0;
        u_bus.i_req = 1'b0;
      end
    end
    step();
    step();
`ifdef MEM_ARB_PERF_EN
    chk("perf_d_grants", perf_d, 32'd16);
    chk("perf_i_grants", perf_i, 32'd4);
    chk("perf_stall_nonzero", 32'(perf_stall != 32'd0), 32'd1);
    chk("perf_stall_final_mono", 32'(perf_stall >= prev_stall), 32'd1);
`endif
    chk("end_idle", 32'(u_bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
